// File: rtl/key_opcode_encoder_if.sv
// Key/operand bus between the calculator keypad front-end and its consumers.
// master drives the raw keys and switches; slave (the encoder) returns the opcode stream.
interface key_opcode_encoder_if #(
   parameter int NUM_WIDTH = 4
);
   logic                 btn_clear;
   logic                 btn_enter;
   logic                 btn_num;
   logic [3:0]           btn_op;
   logic [NUM_WIDTH-1:0] sw_num;
   logic [2:0]           op_code;
   logic                 op_strobe;
   logic [NUM_WIDTH-1:0] number_out;
   logic                 busy;

   modport master (
      output btn_clear, btn_enter, btn_num, btn_op, sw_num,
      input  op_code, op_strobe, number_out, busy
   );

   modport slave (
      input  btn_clear, btn_enter, btn_num, btn_op, sw_num,
      output op_code, op_strobe, number_out, busy
   );
endinterface

// File: rtl/key_opcode_encoder.sv
// Debounced, priority-resolved keypad to 3-bit opcode encoder with one event per press.
// Define KEY_SYNC_EN to add a two-flop synchroniser on every raw key and switch input.
module key_opcode_encoder #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int NUM_WIDTH       = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   key_opcode_encoder_if.slave  keys
);

   typedef enum logic [2:0] {
      IDLE,
      PRESS_CHK,
      EMIT,
      HOLD,
      RELEASE_CHK
   } state_t;

   localparam logic [2:0]  OP_CLEAR  = 3'b000;
   localparam logic [2:0]  OP_NUMBER = 3'b001;
   localparam logic [2:0]  OP_ENTER  = 3'b010;
   localparam logic [2:0]  OP_ADD    = 3'b100;
   localparam logic [2:0]  OP_SUB    = 3'b101;
   localparam logic [2:0]  OP_MUL    = 3'b110;
   localparam logic [2:0]  OP_DIV    = 3'b111;
   localparam logic [15:0] CNT_LAST  = 16'(DEBOUNCE_CYCLES - 1);

   logic [6:0]           kv_raw;
   logic [6:0]           kv;
   logic [NUM_WIDTH-1:0] sw_use;

   assign kv_raw = {keys.btn_op, keys.btn_num, keys.btn_enter, keys.btn_clear};

`ifdef KEY_SYNC_EN
   logic [6:0]           kv_s1_reg;
   logic [6:0]           kv_s2_reg;
   logic [NUM_WIDTH-1:0] sw_s1_reg;
   logic [NUM_WIDTH-1:0] sw_s2_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         kv_s1_reg <= '0;
         kv_s2_reg <= '0;
         sw_s1_reg <= '0;
         sw_s2_reg <= '0;
      end else begin
         kv_s1_reg <= kv_raw;
         kv_s2_reg <= kv_s1_reg;
         sw_s1_reg <= keys.sw_num;
         sw_s2_reg <= sw_s1_reg;
      end
   end

   assign kv     = kv_s2_reg;
   assign sw_use = sw_s2_reg;
`else
   assign kv     = kv_raw;
   assign sw_use = keys.sw_num;
`endif

   // Highest-priority key wins: clear, enter, num, then add/sub/mul/div.
   function automatic logic [2:0] encode(input logic [6:0] snap);
      logic [2:0] code;
      code = OP_CLEAR;
      if (snap[0])      code = OP_CLEAR;
      else if (snap[1]) code = OP_ENTER;
      else if (snap[2]) code = OP_NUMBER;
      else if (snap[3]) code = OP_ADD;
      else if (snap[4]) code = OP_SUB;
      else if (snap[5]) code = OP_MUL;
      else if (snap[6]) code = OP_DIV;
      return code;
   endfunction

   state_t               state_reg,   state_next;
   logic [15:0]          cnt_reg,     cnt_next;
   logic [6:0]           snap_reg,    snap_next;
   logic [2:0]           op_code_reg, op_code_next;
   logic                 strobe_reg,  strobe_next;
   logic [NUM_WIDTH-1:0] num_reg,     num_next;
   logic [2:0]           snap_code;

   assign snap_code = encode(snap_reg);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         snap_reg    <= '0;
         op_code_reg <= OP_CLEAR;
         strobe_reg  <= 1'b0;
         num_reg     <= '0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         snap_reg    <= snap_next;
         op_code_reg <= op_code_next;
         strobe_reg  <= strobe_next;
         num_reg     <= num_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      snap_next    = snap_reg;
      op_code_next = op_code_reg;
      strobe_next  = 1'b0;
      num_next     = num_reg;
      case (state_reg)
         IDLE: begin
            if (kv != 7'd0) begin
               state_next = PRESS_CHK;
               snap_next  = kv;
               cnt_next   = 16'd1;
            end
         end
         PRESS_CHK: begin
            // Any change of pattern, including adding a key, restarts from IDLE.
            if (kv != snap_reg) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
               state_next   = EMIT;
               cnt_next     = '0;
               op_code_next = snap_code;
               strobe_next  = 1'b1;
               if (snap_code == OP_NUMBER)
                  num_next = sw_use;
            end else begin
               cnt_next = cnt_reg + 16'd1;
            end
         end
         EMIT: begin
            state_next = HOLD;
         end
         HOLD: begin
            if (kv == 7'd0) begin
               state_next = RELEASE_CHK;
               cnt_next   = 16'd1;
            end
         end
         RELEASE_CHK: begin
            if (kv != 7'd0) begin
               state_next = HOLD;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 16'd1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   assign keys.op_code    = op_code_reg;
   assign keys.op_strobe  = strobe_reg;
   assign keys.number_out = num_reg;
   assign keys.busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_key_opcode_encoder.sv
// Directed self-checking bench for key_opcode_encoder (DEBOUNCE_CYCLES=4, NUM_WIDTH=4).
// Honours KEY_SYNC_EN by expecting two extra cycles of press latency.
module tb_key_opcode_encoder;

   localparam int D  = 4;
   localparam int NW = 4;
`ifdef KEY_SYNC_EN
   localparam int LAT      = D + 2;
   localparam int PRE_WAIT = 4;
`else
   localparam int LAT      = D;
   localparam int PRE_WAIT = 2;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   key_opcode_encoder_if #(.NUM_WIDTH(NW)) kif ();

   key_opcode_encoder #(
      .DEBOUNCE_CYCLES(D),
      .NUM_WIDTH(NW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .keys  (kif.slave)
   );

   int checks   = 0;
   int failures = 0;

   // Strobe monitor: samples just after each rising edge.
   int         strobe_cnt  = 0;
   int         wide_err    = 0;
   logic       prev_strobe = 1'b0;
   logic [2:0] codes[$];

   always @(posedge clk) begin
      #1;
      if (kif.op_strobe === 1'b1) begin
         strobe_cnt++;
         codes.push_back(kif.op_code);
         if (prev_strobe === 1'b1) wide_err++;
      end
      prev_strobe = kif.op_strobe;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic set_kv(input logic [6:0] v);
      {kif.btn_op, kif.btn_num, kif.btn_enter, kif.btn_clear} = v;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Press a key pattern for 'hold' cycles then release for 'rel' cycles.
   task automatic press(input logic [6:0] v, input int hold, input int rel);
      set_kv(v);
      cycles(hold);
      set_kv(7'd0);
      cycles(rel);
      $display("press kv=%b hold=%0d strobes=%0d op_code=%b number_out=%0d",
               v, hold, strobe_cnt, kif.op_code, kif.number_out);
   endtask

   task automatic test_reset;
      int base;
      reset = 1'b1;
      set_kv(7'd0);
      kif.sw_num = '0;
      #100;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++; if (kif.op_code !== 3'b000) begin failures++; $display("FAIL reset_op_code got=%b exp=000", kif.op_code); end
      checks++; if (kif.op_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", kif.op_strobe); end
      checks++; if (kif.number_out !== 4'd0) begin failures++; $display("FAIL reset_number got=%0d exp=0", kif.number_out); end
      checks++; if (kif.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", kif.busy); end
      base = strobe_cnt;
      cycles(20);
      checks++; if (strobe_cnt - base !== 0) begin failures++; $display("FAIL idle_no_strobe got=%0d exp=0", strobe_cnt - base); end
      checks++; if (kif.busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", kif.busy); end
      $display("reset done op_code=%b busy=%b", kif.op_code, kif.busy);
   endtask

   task automatic test_number_press;
      int base;
      int lat;
      base = strobe_cnt;
      lat  = -1;
      kif.sw_num = 4'd9;
      set_kv(7'b0000100);
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (kif.op_strobe === 1'b1 && lat < 0) lat = i;
         if (i == 6) kif.sw_num = 4'd3;
      end
      checks++; if (kif.busy !== 1'b1) begin failures++; $display("FAIL num_busy_held got=%b exp=1", kif.busy); end
      set_kv(7'd0);
      cycles(2 * D + 4);
      $display("number press lat=%0d op_code=%b number_out=%0d", lat, kif.op_code, kif.number_out);
      checks++; if (lat !== LAT) begin failures++; $display("FAIL num_latency got=%0d exp=%0d", lat, LAT); end
      checks++; if (strobe_cnt - base !== 1) begin failures++; $display("FAIL num_strobes got=%0d exp=1", strobe_cnt - base); end
      checks++; if (kif.op_code !== 3'b001) begin failures++; $display("FAIL num_op_code got=%b exp=001", kif.op_code); end
      checks++; if (kif.number_out !== 4'd9) begin failures++; $display("FAIL num_value got=%0d exp=9", kif.number_out); end
      checks++; if (kif.busy !== 1'b0) begin failures++; $display("FAIL num_busy_rel got=%b exp=0", kif.busy); end
   endtask

   task automatic test_glitch_boundary;
      int base;
      base = strobe_cnt;
      press(7'b0000100, D - 1, D + 4);
      checks++; if (strobe_cnt - base !== 0) begin failures++; $display("FAIL short_glitch got=%0d exp=0", strobe_cnt - base); end
      checks++; if (kif.number_out !== 4'd9) begin failures++; $display("FAIL glitch_number got=%0d exp=9", kif.number_out); end
      press(7'b0001000, D, 2 * D + 4);
      checks++; if (strobe_cnt - base !== 1) begin failures++; $display("FAIL min_press got=%0d exp=1", strobe_cnt - base); end
      checks++; if (kif.op_code !== 3'b100) begin failures++; $display("FAIL min_press_code got=%b exp=100", kif.op_code); end
   endtask

   task automatic test_bounce;
      int base;
      base = strobe_cnt;
      set_kv(7'b0000010); cycles(1);
      set_kv(7'd0);       cycles(1);
      set_kv(7'b0000010); cycles(1);
      set_kv(7'd0);       cycles(1);
      set_kv(7'b0000010); cycles(8);
      checks++; if (kif.busy !== 1'b1) begin failures++; $display("FAIL bounce_busy got=%b exp=1", kif.busy); end
      checks++; if (strobe_cnt - base !== 1) begin failures++; $display("FAIL bounce_press got=%0d exp=1", strobe_cnt - base); end
      checks++; if (kif.op_code !== 3'b010) begin failures++; $display("FAIL bounce_code got=%b exp=010", kif.op_code); end
      set_kv(7'd0);       cycles(1);
      set_kv(7'b0000010); cycles(1);
      set_kv(7'd0);       cycles(1);
      set_kv(7'b0000010); cycles(1);
      set_kv(7'd0);       cycles(2 * D + 4);
      $display("bounce done strobes=%0d op_code=%b", strobe_cnt - base, kif.op_code);
      checks++; if (strobe_cnt - base !== 1) begin failures++; $display("FAIL release_bounce got=%0d exp=1", strobe_cnt - base); end
      checks++; if (kif.busy !== 1'b0) begin failures++; $display("FAIL bounce_idle got=%b exp=0", kif.busy); end
   endtask

   task automatic test_simultaneous;
      int base;
      base = strobe_cnt;
      press(7'b0100001, 8, 2 * D + 4);
      checks++; if (strobe_cnt - base !== 1) begin failures++; $display("FAIL simul_clr_cnt got=%0d exp=1", strobe_cnt - base); end
      checks++; if (kif.op_code !== 3'b000) begin failures++; $display("FAIL simul_clr_code got=%b exp=000", kif.op_code); end
      press(7'b1010000, 8, 2 * D + 4);
      checks++; if (strobe_cnt - base !== 2) begin failures++; $display("FAIL simul_ops_cnt got=%0d exp=2", strobe_cnt - base); end
      checks++; if (kif.op_code !== 3'b101) begin failures++; $display("FAIL simul_ops_code got=%b exp=101", kif.op_code); end
   endtask

   task automatic test_sequence_lockout;
      int qb;
      qb = codes.size();
      kif.sw_num = 4'd5;
      press(7'b0000100, 8, 2 * D + 4);
      press(7'b0001000, 8, 2 * D + 4);
      set_kv(7'b0000010);
      cycles(8);
      press(7'b0100010, 8, 2 * D + 4);
      checks++; if (codes.size() - qb !== 3) begin failures++; $display("FAIL seq_count got=%0d exp=3", codes.size() - qb); end
      if (codes.size() - qb >= 3) begin
         checks++; if (codes[qb] !== 3'b001) begin failures++; $display("FAIL seq_code0 got=%b exp=001", codes[qb]); end
         checks++; if (codes[qb+1] !== 3'b100) begin failures++; $display("FAIL seq_code1 got=%b exp=100", codes[qb+1]); end
         checks++; if (codes[qb+2] !== 3'b010) begin failures++; $display("FAIL seq_code2 got=%b exp=010", codes[qb+2]); end
      end
      checks++; if (kif.number_out !== 4'd5) begin failures++; $display("FAIL seq_number got=%0d exp=5", kif.number_out); end
      checks++; if (kif.op_code !== 3'b010) begin failures++; $display("FAIL lockout_code got=%b exp=010", kif.op_code); end
   endtask

   task automatic test_reset_mid;
      int base;
      base = strobe_cnt;
      set_kv(7'b0100000);
      cycles(PRE_WAIT);
      checks++; if (kif.busy !== 1'b1) begin failures++; $display("FAIL mid_pre_busy got=%b exp=1", kif.busy); end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (kif.op_code !== 3'b000) begin failures++; $display("FAIL mid_op_code got=%b exp=000", kif.op_code); end
      checks++; if (kif.busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", kif.busy); end
      checks++; if (kif.number_out !== 4'd0) begin failures++; $display("FAIL mid_number got=%0d exp=0", kif.number_out); end
      set_kv(7'd0);
      @(negedge clk);
      cycles(2);
      reset = 1'b0;
      cycles(12);
      $display("reset mid-press strobes=%0d op_code=%b", strobe_cnt - base, kif.op_code);
      checks++; if (strobe_cnt - base !== 0) begin failures++; $display("FAIL mid_no_strobe got=%0d exp=0", strobe_cnt - base); end
      press(7'b0100000, 8, 2 * D + 4);
      checks++; if (strobe_cnt - base !== 1) begin failures++; $display("FAIL mid_fresh_cnt got=%0d exp=1", strobe_cnt - base); end
      checks++; if (kif.op_code !== 3'b110) begin failures++; $display("FAIL mid_fresh_code got=%b exp=110", kif.op_code); end
   endtask

   initial begin
      test_reset();
      test_number_press();
      test_glitch_boundary();
      test_bounce();
      test_simultaneous();
      test_sequence_lockout();
      test_reset_mid();
      checks++; if (wide_err !== 0) begin failures++; $display("FAIL strobe_width got=%0d exp=0", wide_err); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
